deserializer_uart_rx: RTL

//  UART receive path, other end of the link driven by the UART TX serializer.

---
 rtl/deserializer_uart_rx.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/deserializer_uart_rx.sv
// ---------------------------------------------------------------------------
// deserializer_uart_rx
//
// UART receive path. It oversamples the asynchronous serial line, detects a
// start bit, and majority-votes three samples taken around the middle of each
// bit cell. It then checks an optional parity bit and the stop bit. A good
// word is presented on P_DATA_DES together with a one-cycle Data_Valid_DES
// strobe. A bad frame raises one-cycle error strobes instead.
//
// Ports
//   CLK_RX          in   oversampling clock
//   RST_RX          in   synchronous reset, active-high
//   RX_IN_DES       in   serial line, idle high, asynchronous to CLK_RX
//   Prescale_DES    in   CLK_RX cycles per bit (even, >= 8 expected)
//   PAR_EN_DES      in   1: frame carries a parity bit
//   PAR_TYP_DES     in   0: even parity, 1: odd parity
//   P_DATA_DES      out  last good received word
//   Data_Valid_DES  out  1-cycle strobe, P_DATA_DES updated this cycle
//   Par_Err_DES     out  1-cycle strobe, parity mismatch
//   Stp_Err_DES     out  1-cycle strobe, stop bit sampled low
//   Busy_DES        out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module deserializer_uart_rx #(
   parameter int DATA_SIZE  = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK_RX,
   input  logic                  RST_RX,
   input  logic                  RX_IN_DES,
   input  logic [PRESCALE_W-1:0] Prescale_DES,
   input  logic                  PAR_EN_DES,
   input  logic                  PAR_TYP_DES,
   output logic [DATA_SIZE-1:0]  P_DATA_DES,
   output logic                  Data_Valid_DES,
   output logic                  Par_Err_DES,
   output logic                  Stp_Err_DES,
   output logic                  Busy_DES
);

   localparam int BCW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                  state;

   logic                    rx_meta;
   logic                    rx_s;

   logic [PRESCALE_W-1:0]   p_lat;
   logic                    par_en_lat;
   logic                    par_typ_lat;

   logic [PRESCALE_W-1:0]   edge_cnt;
   logic [BCW-1:0]          bit_cnt;
   logic [2:0]              samples;
   logic [DATA_SIZE-1:0]    shift_reg;
   logic                    par_err;

   logic [PRESCALE_W-1:0]   p_even;
   logic [PRESCALE_W-1:0]   p_eff;
   logic [PRESCALE_W-1:0]   half;
   logic [PRESCALE_W-1:0]   samp_first;
   logic [PRESCALE_W-1:0]   samp_last;
   logic [PRESCALE_W-1:0]   eval_point;
   logic [PRESCALE_W-1:0]   last_edge;
   logic                    at_eval;
   logic                    at_wrap;
   logic                    vote;
   logic                    par_expected;

   // The prescale input is sanitised before it is latched. Anything below 8
   // leaves no room for three samples plus the evaluate point, so it is
   // clamped to 8. Odd ratios have no exact middle, so their LSB is dropped.
   assign p_even = {Prescale_DES[PRESCALE_W-1:1], 1'b0};
   assign p_eff  = (Prescale_DES < PRESCALE_W'(8)) ? PRESCALE_W'(8) : p_even;

   // Sample points straddle the bit centre. The vote is taken one cycle after
   // the last sample, so all three samples are settled in the register.
   assign half       = {1'b0, p_lat[PRESCALE_W-1:1]};
   assign samp_first = half - PRESCALE_W'(1);
   assign samp_last  = half + PRESCALE_W'(1);
   assign eval_point = half + PRESCALE_W'(2);
   assign last_edge  = p_lat - PRESCALE_W'(1);
   assign at_eval    = (edge_cnt == eval_point);
   assign at_wrap    = (edge_cnt == last_edge);

   assign vote = (samples[0] & samples[1]) |
                 (samples[0] & samples[2]) |
                 (samples[1] & samples[2]);

   // Value the parity bit should carry for the word in the shift register.
   assign par_expected = (^shift_reg) ^ par_typ_lat;

   // Single sequential process. It holds the input synchronizer, the bit
   // timing counters, the receive FSM and the registered result strobes.
   // The strobes default low every cycle. They are raised only in the STOP
   // evaluate cycle.
   always_ff @(posedge CLK_RX) begin
      if (RST_RX) begin
         state          <= IDLE;
         rx_meta        <= 1'b1;
         rx_s           <= 1'b1;
         p_lat          <= PRESCALE_W'(8);
         par_en_lat     <= 1'b0;
         par_typ_lat    <= 1'b0;
         edge_cnt       <= '0;
         bit_cnt        <= '0;
         samples        <= 3'b111;
         shift_reg      <= '0;
         par_err        <= 1'b0;
         P_DATA_DES     <= '0;
         Data_Valid_DES <= 1'b0;
         Par_Err_DES    <= 1'b0;
         Stp_Err_DES    <= 1'b0;
         Busy_DES       <= 1'b0;
      end else begin
         rx_meta        <= RX_IN_DES;
         rx_s           <= rx_meta;
         Data_Valid_DES <= 1'b0;
         Par_Err_DES    <= 1'b0;
         Stp_Err_DES    <= 1'b0;

         if (state != IDLE) begin
            if (edge_cnt == samp_first) begin
               samples[0] <= rx_s;
            end
            if (edge_cnt == half) begin
               samples[1] <= rx_s;
            end
            if (edge_cnt == samp_last) begin
               samples[2] <= rx_s;
            end
         end

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state       <= START;
                  Busy_DES    <= 1'b1;
                  edge_cnt    <= '0;
                  bit_cnt     <= '0;
                  p_lat       <= p_eff;
                  par_en_lat  <= PAR_EN_DES;
                  par_typ_lat <= PAR_TYP_DES;
                  par_err     <= 1'b0;
               end
            end

            // A start bit that votes high was only a glitch. Drop back to
            // idle without reporting anything.
            START: begin
               if (at_eval && vote) begin
                  state    <= IDLE;
                  Busy_DES <= 1'b0;
                  edge_cnt <= '0;
               end else if (at_wrap) begin
                  state    <= DATA;
                  edge_cnt <= '0;
               end else begin
                  edge_cnt <= edge_cnt + PRESCALE_W'(1);
               end
            end

            // The word arrives LSB first. Each voted bit enters at the top
            // and moves down, so bit 0 ends up in position 0.
            DATA: begin
               if (at_eval) begin
                  shift_reg <= {vote, shift_reg[DATA_SIZE-1:1]};
               end
               if (at_wrap) begin
                  edge_cnt <= '0;
                  if (bit_cnt == BCW'(DATA_SIZE - 1)) begin
                     bit_cnt <= '0;
                     state   <= par_en_lat ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + BCW'(1);
                  end
               end else begin
                  edge_cnt <= edge_cnt + PRESCALE_W'(1);
               end
            end

            PARITY: begin
               if (at_eval) begin
                  par_err <= (vote != par_expected);
               end
               if (at_wrap) begin
                  edge_cnt <= '0;
                  state    <= STOP;
               end else begin
                  edge_cnt <= edge_cnt + PRESCALE_W'(1);
               end
            end

            // Results are settled halfway through the stop bit. Returning to
            // IDLE right away lets a back-to-back start edge be caught with
            // no dead time.
            STOP: begin
               if (at_eval) begin
                  Stp_Err_DES    <= ~vote;
                  Par_Err_DES    <= par_err;
                  Data_Valid_DES <= vote & ~par_err;
                  if (vote && !par_err) begin
                     P_DATA_DES <= shift_reg;
                  end
                  state    <= IDLE;
                  Busy_DES <= 1'b0;
                  edge_cnt <= '0;
               end else begin
                  edge_cnt <= edge_cnt + PRESCALE_W'(1);
               end
            end

            default: begin
               state    <= IDLE;
               Busy_DES <= 1'b0;
               edge_cnt <= '0;
            end
         endcase
      end
   end

endmodule
